// File: rtl/substitution_layer_serial_if.sv
// Handshake/data bundle for substitution_layer_serial.
// i_abort exists only when SUBSTITUTION_LAYER_ABORT_EN is defined.
interface substitution_layer_serial_if;
   logic         i_start;
   logic [319:0] i_state;
`ifdef SUBSTITUTION_LAYER_ABORT_EN
   logic         i_abort;
`endif
   logic [319:0] o_state;
   logic         o_busy;
   logic         o_done;

`ifdef SUBSTITUTION_LAYER_ABORT_EN
   modport master (output i_start, i_state, i_abort, input o_state, o_busy, o_done);
   modport slave  (input i_start, i_state, i_abort, output o_state, o_busy, o_done);
`else
   modport master (output i_start, i_state, input o_state, o_busy, o_done);
   modport slave  (input i_start, i_state, output o_state, o_busy, o_done);
`endif
endinterface

// File: rtl/substitution_layer_serial.sv
// Time-multiplexed ASCON substitution layer: SBOX_PER_CYCLE bit-sliced columns per clock.
// Optional abort input is enabled by defining SUBSTITUTION_LAYER_ABORT_EN.
module substitution_layer_sbox (
   input  logic [4:0] i_x,
   output logic [4:0] o_y
);
   always_comb begin
      o_y = 5'h00;
      case (i_x)
         5'h00: o_y = 5'h04;  5'h01: o_y = 5'h0b;  5'h02: o_y = 5'h1f;  5'h03: o_y = 5'h14;
         5'h04: o_y = 5'h1a;  5'h05: o_y = 5'h15;  5'h06: o_y = 5'h09;  5'h07: o_y = 5'h02;
         5'h08: o_y = 5'h1b;  5'h09: o_y = 5'h05;  5'h0a: o_y = 5'h08;  5'h0b: o_y = 5'h12;
         5'h0c: o_y = 5'h1d;  5'h0d: o_y = 5'h03;  5'h0e: o_y = 5'h06;  5'h0f: o_y = 5'h1c;
         5'h10: o_y = 5'h1e;  5'h11: o_y = 5'h13;  5'h12: o_y = 5'h07;  5'h13: o_y = 5'h0e;
         5'h14: o_y = 5'h00;  5'h15: o_y = 5'h0d;  5'h16: o_y = 5'h11;  5'h17: o_y = 5'h18;
         5'h18: o_y = 5'h10;  5'h19: o_y = 5'h0c;  5'h1a: o_y = 5'h01;  5'h1b: o_y = 5'h19;
         5'h1c: o_y = 5'h16;  5'h1d: o_y = 5'h0a;  5'h1e: o_y = 5'h0f;  5'h1f: o_y = 5'h17;
         default: o_y = 5'h00;
      endcase
   end
endmodule

module substitution_layer_serial #(
   parameter int SBOX_PER_CYCLE = 8
) (
   input  logic                        i_clock,
   input  logic                        i_reset,
   substitution_layer_serial_if.slave  bus
);
   localparam int NUM_STEPS = 64 / SBOX_PER_CYCLE;
   localparam int CNT_W     = (NUM_STEPS > 1) ? $clog2(NUM_STEPS) : 1;
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NUM_STEPS - 1);

   if (SBOX_PER_CYCLE != 1 && SBOX_PER_CYCLE != 2 && SBOX_PER_CYCLE != 4 &&
       SBOX_PER_CYCLE != 8 && SBOX_PER_CYCLE != 16 && SBOX_PER_CYCLE != 32 &&
       SBOX_PER_CYCLE != 64) begin : g_bad_param
      $error("SBOX_PER_CYCLE must be a power of two between 1 and 64");
   end

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

   state_e             fsm_q, fsm_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [319:0]       state_q, state_d;

   logic [63:0]        x_q [5];
   logic [63:0]        x_d [5];
   logic [6:0]         base;
   logic [5:0]         col    [SBOX_PER_CYCLE];
   logic [4:0]         sb_in  [SBOX_PER_CYCLE];
   logic [4:0]         sb_out [SBOX_PER_CYCLE];

   // Gather the column slice selected by the step counter; x0 lands on sbox bit 4.
   always_comb begin
      x_q[0] = state_q[319:256];
      x_q[1] = state_q[255:192];
      x_q[2] = state_q[191:128];
      x_q[3] = state_q[127:64];
      x_q[4] = state_q[63:0];
      base   = 7'(cnt_q) * 7'(SBOX_PER_CYCLE);
      for (int k = 0; k < SBOX_PER_CYCLE; k++) begin
         col[k]   = 6'(base + 7'(k));
         sb_in[k] = {x_q[0][col[k]], x_q[1][col[k]], x_q[2][col[k]],
                     x_q[3][col[k]], x_q[4][col[k]]};
      end
   end

   for (genvar k = 0; k < SBOX_PER_CYCLE; k++) begin : g_sbox
      substitution_layer_sbox u_sbox (
         .i_x (sb_in[k]),
         .o_y (sb_out[k])
      );
   end

   always_comb begin
      fsm_d   = fsm_q;
      cnt_d   = cnt_q;
      state_d = state_q;
      x_d     = x_q;
      case (fsm_q)
         IDLE: begin
            if (bus.i_start) begin
               state_d = bus.i_state;
               cnt_d   = '0;
               fsm_d   = RUN;
            end
         end
         RUN: begin
            for (int k = 0; k < SBOX_PER_CYCLE; k++) begin
               {x_d[0][col[k]], x_d[1][col[k]], x_d[2][col[k]],
                x_d[3][col[k]], x_d[4][col[k]]} = sb_out[k];
            end
            state_d = {x_d[0], x_d[1], x_d[2], x_d[3], x_d[4]};
            if (cnt_q == LAST_CNT) begin
               fsm_d = DONE;
               cnt_d = '0;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         DONE: begin
            if (bus.i_start) begin
               state_d = bus.i_state;
               cnt_d   = '0;
               fsm_d   = RUN;
            end else begin
               fsm_d = IDLE;
            end
         end
         default: fsm_d = IDLE;
      endcase
`ifdef SUBSTITUTION_LAYER_ABORT_EN
      // Abort keeps whatever columns were already substituted.
      if (bus.i_abort && fsm_q != IDLE) begin
         fsm_d   = IDLE;
         cnt_d   = '0;
         state_d = state_q;
      end
`endif
   end

   always_ff @(posedge i_clock) begin
      if (i_reset) begin
         fsm_q   <= IDLE;
         cnt_q   <= '0;
         state_q <= '0;
      end else begin
         fsm_q   <= fsm_d;
         cnt_q   <= cnt_d;
         state_q <= state_d;
      end
   end

   assign bus.o_state = state_q;
   assign bus.o_busy  = (fsm_q == RUN);
   assign bus.o_done  = (fsm_q == DONE);
endmodule
